// File: rtl/dmem_master.sv
`default_nettype none
// ============================================================================
// Module   : dmem_master
// Purpose  : MEM-stage data-memory initiator (req/ack, lane steering, load
//            extension). Optional abort-on-timeout when MEM_TIMEOUT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic        w_access, w_misaligned, w_start, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_fmt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("dmem_master: TIMEOUT_CYCLES must be at least 1");
  end

  assign w_access = memread | memwrite;

  always_comb begin
    w_misaligned = 1'b0;
    case (size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = addr[0];
      default: w_misaligned = (addr[1:0] != 2'b00);
    endcase
  end

  assign w_start  = (r_state == S_IDLE) && w_access && !w_misaligned;
  assign addr_err = (r_state == S_IDLE) && w_access &&  w_misaligned;
  assign stall    = w_start || (r_state == S_REQ);
  assign m_req    = (r_state == S_REQ);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    case (size)
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << addr[1:0];
        w_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdata;
      end
    endcase
  end

  // Load formatting works from the format captured at request time.
  always_comb begin
    w_byte = m_rdata[7:0];
    case (r_lane)
      2'd0: w_byte = m_rdata[7:0];
      2'd1: w_byte = m_rdata[15:8];
      2'd2: w_byte = m_rdata[23:16];
      2'd3: w_byte = m_rdata[31:24];
      default: w_byte = m_rdata[7:0];
    endcase
    w_half = r_lane[1] ? m_rdata[31:16] : m_rdata[15:0];
    case (r_size)
      2'b00:   w_fmt = {{24{w_byte[7]  & ~r_unsigned}}, w_byte};
      2'b01:   w_fmt = {{16{w_half[15] & ~r_unsigned}}, w_half};
      default: w_fmt = m_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_bus_err;

  assign w_timeout = (r_state == S_REQ) && !m_ack && (r_cnt == c_cnt_last);
  assign bus_err   = r_bus_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_cnt     <= (r_state == S_REQ) ? r_cnt + 1'b1 : '0;
      r_bus_err <= w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_REQ;
      S_REQ:   if (m_ack || w_timeout) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      m_addr     <= '0;
      m_we       <= 1'b0;
      m_be       <= '0;
      m_wdata    <= '0;
      rdata      <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_lane     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        m_addr     <= {addr[31:2], 2'b00};
        m_we       <= memwrite;
        m_be       <= w_be;
        m_wdata    <= w_wdata;
        r_size     <= size;
        r_unsigned <= unsigned_ld;
        r_lane     <= addr[1:0];
      end
      // Ack outranks a coincident timeout; stores never touch rdata.
      if ((r_state == S_REQ) && m_ack && !m_we)
        rdata <= w_fmt;
      else if (w_timeout && !m_we)
        rdata <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_master
// Purpose  : directed self-checking bench for dmem_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        stall, addr_err, bus_err, m_req, m_we, m_ack;
  logic [31:0] rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  int tests = 0;
  int fails = 0;

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  dmem_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .size(size), .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .addr_err(addr_err), .bus_err(bus_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full handshake starting at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] resp, input int waits);
    memread = rd; memwrite = wr; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
    #1;
    check("stall_c0", stall, 1);
    check("mreq_c0", m_req, 0);
    @(posedge clk); @(negedge clk);
    check("mreq_c1", m_req, 1);
    cap_addr = m_addr; cap_be = m_be; cap_we = m_we; cap_wdata = m_wdata;
    repeat (waits) begin
      check("stall_wait", stall, 1);
      check("mreq_wait", m_req, 1);
      @(posedge clk); @(negedge clk);
    end
    m_ack = 1'b1; m_rdata = resp;
    check("stall_ack", stall, 1);
    @(posedge clk); @(negedge clk);
    m_ack = 1'b0; memread = 1'b0; memwrite = 1'b0;
    check("stall_done", stall, 0);
    check("mreq_done", m_req, 0);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic misaligned(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic [31:0] a);
    memread = rd; memwrite = wr; size = sz; addr = a;
    #1;
    check("aerr_on", addr_err, 1);
    check("aerr_stall", stall, 0);
    @(posedge clk); @(negedge clk);
    check("aerr_mreq", m_req, 0);
    memread = 1'b0; memwrite = 1'b0;
    #1;
    check("aerr_off", addr_err, 0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; memread = 0; memwrite = 0; size = 0; unsigned_ld = 0;
    addr = 0; wdata = 0; m_ack = 0; m_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_mreq", m_req, 0);
    check("rst_mwe", m_we, 0);
    check("rst_aerr", addr_err, 0);
    check("rst_berr", bus_err, 0);
    check("rst_maddr", m_addr, 0);
    check("rst_mbe", m_be, 0);
    check("rst_mwdata", m_wdata, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b0;
    @(negedge clk);

    access(1, 0, 2'b10, 0, 32'h0000_0010, 0, 32'hDEAD_BEEF, 0);
    check("lw_addr", cap_addr, 32'h10);
    check("lw_be", cap_be, 4'b1111);
    check("lw_we", cap_we, 0);
    check("lw_rdata", rdata, 32'hDEAD_BEEF);

    access(0, 1, 2'b00, 0, 32'h0000_0023, 32'h0000_00A5, 32'h1111_1111, 0);
    check("sb_be", cap_be, 4'b1000);
    check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    check("sb_we", cap_we, 1);
    check("sb_addr", cap_addr, 32'h20);
    check("sb_rdata", rdata, 32'hDEAD_BEEF);

    access(1, 1, 2'b10, 0, 32'h0000_0044, 32'h0102_0304, 32'h2222_2222, 0);
    check("rw_we", cap_we, 1);
    check("rw_wdata", cap_wdata, 32'h0102_0304);
    check("rw_rdata", rdata, 32'hDEAD_BEEF);

    access(1, 0, 2'b00, 0, 32'h0000_1001, 0, 32'h1234_80FF, 0);
    check("lb_be", cap_be, 4'b0010);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    access(1, 0, 2'b00, 1, 32'h0000_1001, 0, 32'h1234_80FF, 0);
    check("lbu_rdata", rdata, 32'h0000_0080);
    access(1, 0, 2'b01, 0, 32'h0000_1002, 0, 32'h1234_80FF, 0);
    check("lh_hi_be", cap_be, 4'b1100);
    check("lh_hi_rdata", rdata, 32'h0000_1234);
    access(1, 0, 2'b01, 0, 32'h0000_1000, 0, 32'h1234_80FF, 0);
    check("lh_lo_rdata", rdata, 32'hFFFF_80FF);

    access(0, 1, 2'b01, 0, 32'h0000_2002, 32'h0000_BEEF, 32'h3333_3333, 2);
    check("sh_be", cap_be, 4'b1100);
    check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    check("sh_rdata", rdata, 32'hFFFF_80FF);

    access(1, 0, 2'b00, 1, 32'h0000_3003, 0, 32'hAB00_0000, 1);
    check("lbu3_be", cap_be, 4'b1000);
    check("lbu3_rdata", rdata, 32'h0000_00AB);

    m_ack = 1'b1; m_rdata = 32'h5555_5555;
    @(posedge clk); @(negedge clk);
    m_ack = 1'b0;
    check("stray_ack_mreq", m_req, 0);
    check("stray_ack_rdata", rdata, 32'h0000_00AB);

    misaligned(1, 0, 2'b10, 32'h0000_0006);
    misaligned(0, 1, 2'b01, 32'h0000_0003);
    misaligned(1, 0, 2'b11, 32'h0000_0002);

    // Reset in the third wait cycle of a slow read.
    memread = 1; memwrite = 0; size = 2'b10; unsigned_ld = 0; addr = 32'h80;
    @(posedge clk); @(negedge clk);
    check("rst_tx_mreq1", m_req, 1);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("rst_tx_mreq3", m_req, 1);
    #2 reset = 1'b1; memread = 1'b0;
    #1;
    check("rst_tx_mreq_drop", m_req, 0);
    check("rst_tx_stall_drop", stall, 0);
    check("rst_tx_rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    access(1, 0, 2'b10, 0, 32'h0000_0084, 0, 32'hCAFE_F00D, 0);
    check("post_rst_addr", cap_addr, 32'h84);
    check("post_rst_rdata", rdata, 32'hCAFE_F00D);

    // Unanswered read.
    memread = 1; memwrite = 0; size = 2'b10; addr = 32'h90;
    @(posedge clk); @(negedge clk);
`ifdef MEM_TIMEOUT_EN
    repeat (4) begin
      check("to_mreq", m_req, 1);
      check("to_berr_low", bus_err, 0);
      @(posedge clk); @(negedge clk);
    end
    memread = 1'b0;
    check("to_berr", bus_err, 1);
    check("to_mreq_drop", m_req, 0);
    check("to_stall", stall, 0);
    check("to_rdata", rdata, 0);
    @(posedge clk); @(negedge clk);
    check("to_berr_pulse", bus_err, 0);
`else
    repeat (20) begin
      check("hang_stall", stall, 1);
      check("hang_mreq", m_req, 1);
      check("hang_berr", bus_err, 0);
      @(posedge clk); @(negedge clk);
    end
    m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
    @(posedge clk); @(negedge clk);
    m_ack = 1'b0; memread = 1'b0;
    check("hang_release", stall, 0);
    check("hang_rdata", rdata, 32'h0BAD_F00D);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_master.md
Name: dmem_master

Overview:
- Processor-side initiator for data memory; converts the MEM-stage load/store controls into a req/ack handshake with a multi-cycle memory responder.
- Generates the pipeline stall, byte-lane enables, store-data replication and load extraction with sign/zero extension.
- Sits between the MEM-stage pipeline register and the external data memory, replacing the direct single-cycle RAM hookup.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in REQ without m_ack before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- memread  in  1  load request from MEM stage
- memwrite  in  1  store request from MEM stage
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- unsigned_ld  in  1  1 = zero-extend load (lbu/lhu), 0 = sign-extend
- addr  in  32  byte address
- wdata  in  32  store data (right-aligned)
- stall  out  1  freeze pipeline while access in flight
- rdata  out  32  formatted load result
- addr_err  out  1  misaligned access pulse
- bus_err  out  1  timeout abort pulse (0 without MEM_TIMEOUT_EN)
- m_req  out  1  memory request
- m_we  out  1  1 = write
- m_addr  out  32  word address {addr[31:2],2'b00}
- m_be  out  4  byte enables, lane i = bits [8i+7:8i]
- m_wdata  out  32  lane-replicated store data
- m_ack  in  1  responder completion, valid only while m_req=1
- m_rdata  in  32  read data, valid with m_ack

Behaviour:
- Clock/reset: reset reset, asynchronous, active-high; clock clk. Reset: state IDLE; stall, m_req, m_we, addr_err, bus_err = 0; m_addr, m_be, m_wdata, rdata = 0. Reset mid-transaction drops m_req immediately; no completion is reported.
- States: IDLE, REQ, DONE.
- IDLE:
  - access = memread|memwrite. Both high is treated as a write.
  - Misaligned (half with addr[0]=1; word/11 with addr[1:0]!=0): addr_err=1 that cycle (combinational), no stall, no transaction, stay IDLE.
  - Aligned access: stall=1 combinationally. Register m_addr, m_we, m_be, m_wdata and the load format (size, unsigned_ld, addr[1:0]); go to REQ.
- REQ:
  - m_req=1, stall=1, all m_* outputs stable.
  - On m_ack=1: load latches formatted m_rdata into rdata; store leaves rdata unchanged. Go to DONE.
- DONE:
  - m_req=0, stall=0 for exactly one cycle so the pipeline advances; go to IDLE unconditionally.
  - Back-to-back accesses therefore have at least one idle memory cycle between requests.
- Latency: access seen in cycle 0, m_req high in cycle 1; with ack in cycle 1, stall is high in cycles 0–1 and low in cycle 2. Each extra wait cycle adds one stall cycle.
- Pipeline inputs are held stable by the stage while stall=1 and are not re-sampled in REQ/DONE.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extraction: byte = lane addr[1:0]; half = bits [15:0] (addr[1]=0) or [31:16] (addr[1]=1). Extend to 32 bits with sign, or zero if unsigned_ld. Word is passed through.
- rdata holds its value until the next completed load.
- m_ack while m_req=0 is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter clears on entering REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: bus_err=1 for one cycle, m_req drops, go to DONE. rdata is set to 0 for loads and left unchanged for stores.
  - Ack and timeout in the same cycle: ack wins, no bus_err.
- Not defined: no counter; REQ waits indefinitely; bus_err tied 0.

Test Plan:
- lw addr=0x0000_0010, responder acks on first REQ cycle with m_rdata=0xDEAD_BEEF -> m_addr=0x10, m_be=1111, m_we=0, stall high 2 cycles, rdata=0xDEADBEEF in DONE cycle.
- sb addr=0x0000_0023 wdata=0x0000_00A5 -> m_be=1000, m_wdata=0xA5A5_A5A5, m_we=1, m_addr=0x20; rdata unchanged.
- lb addr=0x...01 and then lbu, with m_rdata=0x1234_80FF -> rdata=0xFFFF_FF80, then rdata=0x0000_0080. lh addr=0x...02 -> 0x0000_1234.
- lw addr=0x0000_0006 -> addr_err pulse 1 cycle, m_req never asserts, stall stays 0. sh addr=0x...03 -> same.
- Responder inserts 5 wait cycles, then reset asserted in wait cycle 3 -> m_req, stall drop asynchronously; after release state IDLE, next lw completes normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> m_req high 4 cycles, bus_err pulse, rdata=0, stall released next cycle. Without macro -> stall held indefinitely, bus_err=0.
